// File: rtl/morse_decoder_core.sv
// Morse key decoder: synchronises and debounces a raw key, classifies presses
// as dot/dash, gathers up to MAX_SYM symbols per letter and emits ASCII on
// letter gaps (A-Z, optionally 0-9) plus a single space on word gaps.
// Latency: key edge -> FSM action is 2 sync + DEBOUNCE_CYC + 1 cycles; symbol
// strobes one cycle after the debounced fall; char strobes one cycle after the
// gap count is reached. No backpressure: all strobes are fire-and-forget.
// Ports: clk, rst_n (async active-low, release synchronised internally),
// key_in (raw, async), dot_pulse/dash_pulse/char_valid (1-cycle strobes),
// char_ascii/char_err (held between strobes), sym_count, busy.
// Optional feature: define MORSE_DIGITS_EN to decode the 5-symbol digits 0-9.
module morse_decoder_core #(
  parameter int DEBOUNCE_CYC   = 100000,
  parameter int DOT_MAX_CYC    = 25000000,
  parameter int LETTER_GAP_CYC = 50000000,
  parameter int WORD_GAP_CYC   = 150000000,
  parameter int MAX_SYM        = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         key_in,
  output logic                         dot_pulse,
  output logic                         dash_pulse,
  output logic                         char_valid,
  output logic [7:0]                   char_ascii,
  output logic                         char_err,
  output logic [$clog2(MAX_SYM+1)-1:0] sym_count,
  output logic                         busy
);

  localparam int CW = $clog2(WORD_GAP_CYC + 1);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int SW = $clog2(MAX_SYM + 1);

  localparam logic [CW-1:0] DOT_LIM    = CW'(DOT_MAX_CYC);
  localparam logic [CW-1:0] DOT_SAT    = CW'(DOT_MAX_CYC + 1);
  localparam logic [CW-1:0] LETTER_LIM = CW'(LETTER_GAP_CYC);
  localparam logic [CW-1:0] WORD_LIM   = CW'(WORD_GAP_CYC);
  localparam logic [DW-1:0] DB_LIM     = DW'(DEBOUNCE_CYC - 1);
  localparam logic [SW-1:0] SYM_FULL   = SW'(MAX_SYM);

  // Elaboration-time parameter sanity.
  generate
    if (MAX_SYM < 4 || MAX_SYM > 6) begin : g_chk_sym
      $error("morse_decoder_core: MAX_SYM must be in 4..6");
    end
    if (WORD_GAP_CYC <= LETTER_GAP_CYC) begin : g_chk_gap
      $error("morse_decoder_core: WORD_GAP_CYC must exceed LETTER_GAP_CYC");
    end
    if (DOT_MAX_CYC >= WORD_GAP_CYC) begin : g_chk_dot
      $error("morse_decoder_core: DOT_MAX_CYC must be below WORD_GAP_CYC");
    end
`ifdef MORSE_DIGITS_EN
    if (MAX_SYM < 5) begin : g_chk_dig
      $error("morse_decoder_core: digit decoding needs MAX_SYM >= 5");
    end
`endif
  endgenerate

  // ---------------------------------------------------------------------
  // Reset: asserted asynchronously, released through two flops so the first
  // FSM action lands no earlier than the second cycle after release.
  // ---------------------------------------------------------------------
  logic [1:0] rst_pipe;
  logic       rst_core_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_pipe <= 2'b00;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end

  assign rst_core_n = rst_pipe[1];

  // ---------------------------------------------------------------------
  // Key synchroniser and debouncer. The debounced level flips only after
  // DEBOUNCE_CYC consecutive samples disagree with it; the flip also raises
  // a one-cycle rise/fall event for the FSM.
  // ---------------------------------------------------------------------
  logic [1:0]    key_sync;
  logic          key_s;
  logic          key_db;
  logic [DW-1:0] db_cnt;
  logic          db_rise;
  logic          db_fall;

  assign key_s = key_sync[1];

  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n) begin
      key_sync <= 2'b00;
      key_db   <= 1'b0;
      db_cnt   <= '0;
      db_rise  <= 1'b0;
      db_fall  <= 1'b0;
    end else begin
      key_sync <= {key_sync[0], key_in};
      db_rise  <= 1'b0;
      db_fall  <= 1'b0;
      if (key_s == key_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LIM) begin
        key_db  <= key_s;
        db_cnt  <= '0;
        db_rise <= key_s;
        db_fall <= ~key_s;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Pattern decode. Symbol i of the letter sits at bit i (dot=0, dash=1);
  // bits at or above the symbol count are always zero because the symbol
  // register is cleared at every letter boundary. Returns {err, ascii}.
  // ---------------------------------------------------------------------
  function automatic logic [8:0] decode(input logic [SW-1:0]      len,
                                        input logic [MAX_SYM-1:0] bits,
                                        input logic               ovf);
    logic [5:0] p;
    logic [7:0] a;
    p = '0;
    p[MAX_SYM-1:0] = bits;
    a = 8'h3F;
    case (int'(len))
      1: case (p)
        6'd0: a = 8'h45;  // E .
        6'd1: a = 8'h54;  // T -
        default: a = 8'h3F;
      endcase
      2: case (p)
        6'd0: a = 8'h49;  // I ..
        6'd2: a = 8'h41;  // A .-
        6'd1: a = 8'h4E;  // N -.
        6'd3: a = 8'h4D;  // M --
        default: a = 8'h3F;
      endcase
      3: case (p)
        6'd0: a = 8'h53;  // S ...
        6'd4: a = 8'h55;  // U ..-
        6'd2: a = 8'h52;  // R .-.
        6'd6: a = 8'h57;  // W .--
        6'd1: a = 8'h44;  // D -..
        6'd5: a = 8'h4B;  // K -.-
        6'd3: a = 8'h47;  // G --.
        6'd7: a = 8'h4F;  // O ---
        default: a = 8'h3F;
      endcase
      4: case (p)
        6'd0:  a = 8'h48;  // H ....
        6'd8:  a = 8'h56;  // V ...-
        6'd4:  a = 8'h46;  // F ..-.
        6'd2:  a = 8'h4C;  // L .-..
        6'd6:  a = 8'h50;  // P .--.
        6'd14: a = 8'h4A;  // J .---
        6'd1:  a = 8'h42;  // B -...
        6'd9:  a = 8'h58;  // X -..-
        6'd5:  a = 8'h43;  // C -.-.
        6'd13: a = 8'h59;  // Y -.--
        6'd3:  a = 8'h5A;  // Z --..
        6'd11: a = 8'h51;  // Q --.-
        default: a = 8'h3F;
      endcase
`ifdef MORSE_DIGITS_EN
      5: case (p)
        6'd31: a = 8'h30;  // 0 -----
        6'd30: a = 8'h31;  // 1 .----
        6'd28: a = 8'h32;  // 2 ..---
        6'd24: a = 8'h33;  // 3 ...--
        6'd16: a = 8'h34;  // 4 ....-
        6'd0:  a = 8'h35;  // 5 .....
        6'd1:  a = 8'h36;  // 6 -....
        6'd3:  a = 8'h37;  // 7 --...
        6'd7:  a = 8'h38;  // 8 ---..
        6'd15: a = 8'h39;  // 9 ----.
        default: a = 8'h3F;
      endcase
`endif
      default: a = 8'h3F;
    endcase
    if (ovf) begin
      a = 8'h3F;
    end
    return {(a == 8'h3F), a};
  endfunction

  // ---------------------------------------------------------------------
  // Main FSM with registered outputs.
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {IDLE, PRESS, GAP, WORDWAIT} state_t;

  state_t             state;
  logic [CW-1:0]      press_cnt;
  logic [CW-1:0]      gap_cnt;
  logic [CW-1:0]      gap_inc;
  logic [MAX_SYM-1:0] sym_bits;
  logic               overflow;

  // The gap counter leaves WORDWAIT at WORD_LIM, so this never wraps.
  assign gap_inc = gap_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state      <= IDLE;
      press_cnt  <= '0;
      gap_cnt    <= '0;
      sym_bits   <= '0;
      overflow   <= 1'b0;
      sym_count  <= '0;
      dot_pulse  <= 1'b0;
      dash_pulse <= 1'b0;
      char_valid <= 1'b0;
      char_ascii <= 8'h00;
      char_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      dot_pulse  <= 1'b0;
      dash_pulse <= 1'b0;
      char_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (db_rise) begin
            state     <= PRESS;
            press_cnt <= '0;
            busy      <= 1'b1;
          end
        end

        PRESS: begin
          if (press_cnt != DOT_SAT) begin
            press_cnt <= press_cnt + 1'b1;
          end
          if (db_fall) begin
            state      <= GAP;
            gap_cnt    <= '0;
            dot_pulse  <= (press_cnt <= DOT_LIM);
            dash_pulse <= (press_cnt >  DOT_LIM);
            if (sym_count == SYM_FULL) begin
              // Letter already full: drop the symbol, remember the overflow.
              overflow <= 1'b1;
            end else begin
              for (int i = 0; i < MAX_SYM; i++) begin
                if (SW'(i) == sym_count) begin
                  sym_bits[i] <= (press_cnt > DOT_LIM);
                end
              end
              sym_count <= sym_count + 1'b1;
            end
          end
        end

        GAP: begin
          gap_cnt <= gap_inc;
          if (gap_inc == LETTER_LIM) begin
            {char_err, char_ascii} <= decode(sym_count, sym_bits, overflow);
            char_valid <= 1'b1;
            sym_bits   <= '0;
            sym_count  <= '0;
            overflow   <= 1'b0;
            // A coincident rise starts the next letter after this one is out.
            if (db_rise) begin
              state     <= PRESS;
              press_cnt <= '0;
            end else begin
              state <= WORDWAIT;
            end
          end else if (db_rise) begin
            state     <= PRESS;
            press_cnt <= '0;
          end
        end

        WORDWAIT: begin
          gap_cnt <= gap_inc;
          if (gap_inc == WORD_LIM) begin
            char_valid <= 1'b1;
            char_ascii <= 8'h20;
            char_err   <= 1'b0;
            if (db_rise) begin
              state     <= PRESS;
              press_cnt <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (db_rise) begin
            state     <= PRESS;
            press_cnt <= '0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_decoder_core.sv
// Directed bench for morse_decoder_core with small timing parameters.
// Each task drives one scenario and checks strobe counts and decoded chars.
module tb_morse_decoder_core;

  localparam int DEB  = 4;
  localparam int DOTM = 20;
  localparam int LGAP = 40;
  localparam int WGAP = 100;
  localparam int MSYM = 5;
  localparam int SCW  = $clog2(MSYM + 1);

  logic           clk;
  logic           rst_n;
  logic           key_in;
  logic           dot_pulse;
  logic           dash_pulse;
  logic           char_valid;
  logic [7:0]     char_ascii;
  logic           char_err;
  logic [SCW-1:0] sym_count;
  logic           busy;

  int checks = 0;
  int errors = 0;

  // Monitor state (written only by the monitor process).
  int         n_dot  = 0;
  int         n_dash = 0;
  int         n_char = 0;
  int         n_ovl  = 0;
  logic [7:0] ch_a [0:63];
  logic       ch_e [0:63];

  // Written only by the stimulus process.
  int max_sym = 0;

  morse_decoder_core #(
    .DEBOUNCE_CYC  (DEB),
    .DOT_MAX_CYC   (DOTM),
    .LETTER_GAP_CYC(LGAP),
    .WORD_GAP_CYC  (WGAP),
    .MAX_SYM       (MSYM)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .dot_pulse (dot_pulse),
    .dash_pulse(dash_pulse),
    .char_valid(char_valid),
    .char_ascii(char_ascii),
    .char_err  (char_err),
    .sym_count (sym_count),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dot_pulse === 1'b1) n_dot++;
    if (dash_pulse === 1'b1) n_dash++;
    if (char_valid === 1'b1) begin
      if (n_char < 64) begin
        ch_a[n_char] = char_ascii;
        ch_e[n_char] = char_err;
      end
      n_char++;
    end
    if ((int'(dot_pulse === 1'b1) + int'(dash_pulse === 1'b1) +
         int'(char_valid === 1'b1)) > 1) n_ovl++;
  end

  task automatic hold(input logic lvl, input int n);
    key_in = lvl;
    repeat (n) begin
      @(negedge clk);
      if (int'(sym_count) > max_sym) max_sym = int'(sym_count);
    end
  endtask

  task automatic send_sym(input logic dash, input int gap);
    hold(1'b1, dash ? 30 : 10);
    hold(1'b0, gap);
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    key_in = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (char_ascii !== 8'h00) begin errors++; $display("FAIL reset_ascii: got %h expected 00", char_ascii); end
    checks++; if ({dot_pulse, dash_pulse, char_valid, char_err} !== 4'b0000) begin errors++; $display("FAIL reset_strobes: got %b expected 0000", {dot_pulse, dash_pulse, char_valid, char_err}); end
    checks++; if (sym_count !== '0) begin errors++; $display("FAIL reset_sym_count: got %0d expected 0", sym_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst_n = 1'b1;
    hold(1'b0, 10);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_letter_e;
    int bd, bs, bc;
    bd = n_dot; bs = n_dash; bc = n_char;
    send_sym(1'b0, 160);
    checks++; if (n_dot - bd !== 1) begin errors++; $display("FAIL e_dots: got %0d expected 1", n_dot - bd); end
    checks++; if (n_dash - bs !== 0) begin errors++; $display("FAIL e_dashes: got %0d expected 0", n_dash - bs); end
    checks++; if (n_char - bc !== 2) begin errors++; $display("FAIL e_nchar: got %0d expected 2", n_char - bc); end
    checks++; if ({ch_e[bc], ch_a[bc]} !== {1'b0, 8'h45}) begin errors++; $display("FAIL e_char: got %h/%b expected 45/0", ch_a[bc], ch_e[bc]); end
    checks++; if ({ch_e[bc+1], ch_a[bc+1]} !== {1'b0, 8'h20}) begin errors++; $display("FAIL e_space: got %h/%b expected 20/0", ch_a[bc+1], ch_e[bc+1]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL e_busy: got %b expected 0", busy); end
    checks++; if (char_ascii !== 8'h20) begin errors++; $display("FAIL e_hold: got %h expected 20", char_ascii); end
  endtask

  task automatic test_letter_a;
    int bd, bs, bc;
    bd = n_dot; bs = n_dash; bc = n_char;
    send_sym(1'b0, 15);
    checks++; if (sym_count !== SCW'(1)) begin errors++; $display("FAIL a_sym_count: got %0d expected 1", sym_count); end
    send_sym(1'b1, 160);
    checks++; if (n_dot - bd !== 1 || n_dash - bs !== 1) begin errors++; $display("FAIL a_syms: got dots %0d dashes %0d expected 1 1", n_dot - bd, n_dash - bs); end
    checks++; if (n_char - bc !== 2) begin errors++; $display("FAIL a_nchar: got %0d expected 2", n_char - bc); end
    checks++; if ({ch_e[bc], ch_a[bc]} !== {1'b0, 8'h41}) begin errors++; $display("FAIL a_char: got %h/%b expected 41/0", ch_a[bc], ch_e[bc]); end
  endtask

  task automatic test_letters;
    // {length, pattern (bit0 = first symbol, 1 = dash), expected ASCII}
    int         len [7]  = '{1, 3, 3, 4, 4, 3, 4};
    logic [5:0] pat [7]  = '{6'd1, 6'd0, 6'd7, 6'd11, 6'd3, 6'd5, 6'd14};
    logic [7:0] exp_a[7] = '{8'h54, 8'h53, 8'h4F, 8'h51, 8'h5A, 8'h4B, 8'h4A};
    for (int k = 0; k < 7; k++) begin
      int bc;
      logic [5:0] p;
      bc = n_char;
      p = pat[k];
      for (int i = 0; i < len[k]; i++) send_sym(p[i], (i == len[k] - 1) ? 160 : 15);
      checks++; if (n_char - bc !== 2 || {ch_e[bc], ch_a[bc]} !== {1'b0, exp_a[k]}) begin errors++; $display("FAIL letter_%0d: got %h/%b (n=%0d) expected %h/0", k, ch_a[bc], ch_e[bc], n_char - bc, exp_a[k]); end
    end
  endtask

  task automatic test_overflow;
    int bd, bc;
    bd = n_dot; bc = n_char; max_sym = 0;
    for (int i = 0; i < 6; i++) send_sym(1'b0, 15);
    checks++; if (sym_count !== SCW'(5)) begin errors++; $display("FAIL ovf_sym_count: got %0d expected 5", sym_count); end
    hold(1'b0, 150);
    checks++; if (max_sym !== 5) begin errors++; $display("FAIL ovf_max_sym: got %0d expected 5", max_sym); end
    checks++; if (n_dot - bd !== 6) begin errors++; $display("FAIL ovf_dots: got %0d expected 6", n_dot - bd); end
    checks++; if ({ch_e[bc], ch_a[bc]} !== {1'b1, 8'h3F}) begin errors++; $display("FAIL ovf_char: got %h/%b expected 3f/1", ch_a[bc], ch_e[bc]); end
    checks++; if ({ch_e[bc+1], ch_a[bc+1]} !== {1'b0, 8'h20}) begin errors++; $display("FAIL ovf_space: got %h/%b expected 20/0", ch_a[bc+1], ch_e[bc+1]); end
  endtask

  task automatic test_digit;
    int bs, bc;
    logic [8:0] exp_c;
`ifdef MORSE_DIGITS_EN
    exp_c = {1'b0, 8'h30};
`else
    exp_c = {1'b1, 8'h3F};
`endif
    bs = n_dash; bc = n_char;
    for (int i = 0; i < 5; i++) send_sym(1'b1, (i == 4) ? 160 : 15);
    checks++; if (n_dash - bs !== 5) begin errors++; $display("FAIL digit_dashes: got %0d expected 5", n_dash - bs); end
    checks++; if ({ch_e[bc], ch_a[bc]} !== exp_c) begin errors++; $display("FAIL digit_char: got %b/%h expected %b/%h", ch_e[bc], ch_a[bc], exp_c[8], exp_c[7:0]); end
  endtask

  task automatic test_glitch;
    int bd, bs, bc;
    bd = n_dot; bs = n_dash; bc = n_char;
    hold(1'b1, 3);
    hold(1'b0, 30);
    checks++; if (n_dot - bd + n_dash - bs + n_char - bc !== 0) begin errors++; $display("FAIL glitch_strobes: got %0d expected 0", n_dot - bd + n_dash - bs + n_char - bc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid;
    int bc;
    bc = n_char;
    send_sym(1'b0, 15);
    send_sym(1'b0, 15);
    hold(1'b1, 8);
    checks++; if (sym_count !== SCW'(2) || busy !== 1'b1) begin errors++; $display("FAIL rmid_before: got sym %0d busy %b expected 2 1", sym_count, busy); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (sym_count !== '0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_async: got sym %0d busy %b expected 0 0", sym_count, busy); end
    hold(1'b0, 3);
    rst_n = 1'b1;
    hold(1'b0, 200);
    checks++; if (n_char - bc !== 0) begin errors++; $display("FAIL rmid_no_char: got %0d expected 0", n_char - bc); end
    checks++; if (sym_count !== '0) begin errors++; $display("FAIL rmid_sym_count: got %0d expected 0", sym_count); end
  endtask

  task automatic test_back_to_back;
    int bc;
    bc = n_char;
    send_sym(1'b0, 60);   // E, letter gap only
    send_sym(1'b1, 160);  // T, then word gap
    checks++; if (n_char - bc !== 3) begin errors++; $display("FAIL b2b_nchar: got %0d expected 3", n_char - bc); end
    checks++; if ({ch_a[bc], ch_a[bc+1], ch_a[bc+2]} !== {8'h45, 8'h54, 8'h20}) begin errors++; $display("FAIL b2b_chars: got %h %h %h expected 45 54 20", ch_a[bc], ch_a[bc+1], ch_a[bc+2]); end
    checks++; if (n_ovl !== 0) begin errors++; $display("FAIL strobe_overlap: got %0d expected 0", n_ovl); end
  endtask

  initial begin
    test_reset();
    test_letter_e();
    test_letter_a();
    test_letters();
    test_overflow();
    test_digit();
    test_glitch();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
